// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int          BCD_W       = 4;
   localparam logic [3:0]  ADD3_THRESH = 4'd5;

   // ceil(n * log10(2)) in fixed point; lets instantiators size DIGITS for an N-bit input.
   function automatic int digits_for_bits(input int n);
      return (n * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 ahead of the next shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] din,
   output logic [BCD_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (din >= ADD3_THRESH) begin
         dout = din + BCD_W'(3);
      end
   end

endmodule

// File: rtl/binary_to_decimal_seq.sv
// Bit-serial binary-to-BCD converter with valid/ready handshakes, optional signed input,
// sticky overflow flag and a leading-zero blanking mask.
module binary_to_decimal_seq
   import bcd_pkg::*;
#(
   parameter int N      = 20,
   parameter int DIGITS = 7,
   parameter bit SIGNED = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N-1:0]            in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BCD_W*DIGITS-1:0] bcd,
   output logic                    neg,
   output logic                    ovf,
   output logic [DIGITS-1:0]       blank
);

   localparam int CNT_W = $clog2(N + 1);
   localparam int BW    = BCD_W * DIGITS;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     mag_q, mag_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
   logic [BW-1:0]    adj;
   logic [N-1:0]     in_mag;
   logic             in_is_neg;
   logic             zero_run;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (bcd_q[g*BCD_W +: BCD_W]),
         .dout (adj[g*BCD_W +: BCD_W])
      );
   end

   // Negating as N-bit unsigned maps the most negative value onto 2^(N-1).
   assign in_is_neg = SIGNED && in_data[N-1];
   assign in_mag    = in_is_neg ? (-in_data) : in_data;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mag_d     = mag_q;
      bcd_d     = bcd_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mag_d   = in_mag;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               neg_d   = in_is_neg;
               cnt_d   = CNT_W'(N);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // A one leaving the top digit means the value needs more digits than we have.
            bcd_d = {adj[BW-2:0], mag_q[N-1]};
            mag_d = {mag_q[N-2:0], 1'b0};
            ovf_d = ovf_q | adj[BW-1];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mag_q   <= '0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   // Walk down from the top digit; digit 0 is never blanked so zero still shows "0".
   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (bcd_q[i*BCD_W +: BCD_W] == '0);
         blank[i] = zero_run && (i != 0);
      end
   end

   assign bcd = bcd_q;
   assign neg = neg_q;
   assign ovf = ovf_q;

endmodule
